// File: rtl/load_store_unit_if.sv
// Core request/response and data-memory port bundle for load_store_unit.
// slave  : the load/store unit (takes requests, drives the memory port).
// master : the surrounding environment (issues requests, models the memory).
// Signals: req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata,
//          resp_valid/resp_rdata/resp_err, MemRead/MemWrite/a/wd/Funct3/rd.
interface load_store_unit_if #(
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DATA_W     = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [DM_ADDRESS-1:0] req_addr;
  logic [DATA_W-1:0]     req_wdata;

  logic                  resp_valid;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  resp_err;

  logic                  MemRead;
  logic                  MemWrite;
  logic [DM_ADDRESS-1:0] a;
  logic [DATA_W-1:0]     wd;
  logic [2:0]            Funct3;
  logic [DATA_W-1:0]     rd;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rd,
    output req_ready, resp_valid, resp_rdata, resp_err,
           MemRead, MemWrite, a, wd, Funct3
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rd,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           MemRead, MemWrite, a, wd, Funct3
  );
endinterface

// File: rtl/load_store_unit.sv
// Core-side initiator for a word-only data memory. Accepts one request at a
// time, issues word-aligned reads/writes, extracts and extends sub-word load
// data, and performs read-modify-write for byte/half stores.
// Ports: clk, reset_n (async active-low), bus (load_store_unit_if.slave):
//   request handshake in, single-cycle response pulse out, memory port out/rd in.
module load_store_unit #(
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  load_store_unit_if.slave      bus
);

  localparam logic [2:0] F3_WORD = 3'b010;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            f3_q, f3_d;
  logic [1:0]            lane_q, lane_d;
  logic [15:0]           wdata_q, wdata_d;

  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]     resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q, resp_err_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [DM_ADDRESS-1:0] a_q, a_d;
  logic [DATA_W-1:0]     wd_q, wd_d;
  logic [2:0]            funct3_q, funct3_d;

  logic                  accept_c;
  logic                  req_err_c;
  logic [7:0]            byte_c;
  logic [15:0]           half_c;
  logic [DATA_W-1:0]     load_c;
  logic [DATA_W-1:0]     merge_c;

  // Request legality: unknown funct3, unsigned-style store codes, misalignment.
  always_comb begin
    req_err_c = 1'b0;
    if (bus.req_funct3 == 3'b011 || bus.req_funct3 == 3'b110 || bus.req_funct3 == 3'b111)
      req_err_c = 1'b1;
    if (bus.req_we && bus.req_funct3[2])
      req_err_c = 1'b1;
    if (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0])
      req_err_c = 1'b1;
    if (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00)
      req_err_c = 1'b1;
  end

  // Lane selection from the word returned in RD.
  always_comb begin
    case (lane_q)
      2'd0:    byte_c = bus.rd[7:0];
      2'd1:    byte_c = bus.rd[15:8];
      2'd2:    byte_c = bus.rd[23:16];
      default: byte_c = bus.rd[31:24];
    endcase
    half_c = lane_q[1] ? bus.rd[31:16] : bus.rd[15:0];
  end

  // Load extension by funct3.
  always_comb begin
    case (f3_q)
      3'b000:  load_c = {{24{byte_c[7]}}, byte_c};
      3'b100:  load_c = {24'd0, byte_c};
      3'b001:  load_c = {{16{half_c[15]}}, half_c};
      3'b101:  load_c = {16'd0, half_c};
      default: load_c = bus.rd;
    endcase
  end

  // Sub-word store merge: replace the addressed lane, keep the rest of the word.
  always_comb begin
    merge_c = bus.rd;
    if (f3_q[0]) begin
      if (lane_q[1]) merge_c[31:16] = wdata_q;
      else           merge_c[15:0]  = wdata_q;
    end else begin
      case (lane_q)
        2'd0:    merge_c[7:0]   = wdata_q[7:0];
        2'd1:    merge_c[15:8]  = wdata_q[7:0];
        2'd2:    merge_c[23:16] = wdata_q[7:0];
        default: merge_c[31:24] = wdata_q[7:0];
      endcase
    end
  end

  assign accept_c = bus.req_valid & req_ready_q;

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    f3_d         = f3_q;
    lane_d       = lane_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    a_d          = a_q;
    wd_d         = wd_q;
    funct3_d     = funct3_q;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          we_d    = bus.req_we;
          f3_d    = bus.req_funct3;
          lane_d  = bus.req_addr[1:0];
          wdata_d = bus.req_wdata[15:0];
          if (req_err_c) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else if (bus.req_we && bus.req_funct3[1:0] == 2'b10) begin
            state_d     = WR;
            mem_write_d = 1'b1;
            a_d         = {bus.req_addr[DM_ADDRESS-1:2], 2'b00};
            wd_d        = bus.req_wdata;
            funct3_d    = F3_WORD;
          end else begin
            // Loads and byte/half stores both start with a word read.
            state_d    = RD;
            mem_read_d = 1'b1;
            a_d        = {bus.req_addr[DM_ADDRESS-1:2], 2'b00};
            funct3_d   = F3_WORD;
          end
        end
      end
      RD: begin
        if (we_q) begin
          state_d     = WR;
          mem_write_d = 1'b1;
          wd_d        = merge_c;
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = load_c;
        end
      end
      WR: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_ready_d = (state_d == IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      f3_q         <= 3'd0;
      lane_q       <= 2'd0;
      wdata_q      <= 16'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      a_q          <= '0;
      wd_q         <= '0;
      funct3_q     <= 3'd0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      f3_q         <= f3_d;
      lane_q       <= lane_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      a_q          <= a_d;
      wd_q         <= wd_d;
      funct3_q     <= funct3_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.MemRead    = mem_read_q;
  assign bus.MemWrite   = mem_write_q;
  assign bus.a          = a_q;
  assign bus.wd         = wd_q;
  assign bus.Funct3     = funct3_q;

endmodule
